// File: rtl/chip_dram_if_model_if.sv
// Shared chip-harness DRAM bus: the FPGA harness is the master, the chip model is the slave.
interface chip_dram_if_model_if;
    logic         execute;
    logic         encrypt;
    logic         dram_read_ready;
    logic         dram_write_ready;
    logic         data_vld;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         data_oe;
    logic         addr_wvalid;
    logic [19:0]  dram_addr;
    logic         command_type;
    logic         done;
    logic         err;

    modport master (
        output execute, encrypt, dram_read_ready, dram_write_ready, data_vld, data_in,
        input  data_out, data_oe, addr_wvalid, dram_addr, command_type, done, err
    );

    modport slave (
        input  execute, encrypt, dram_read_ready, dram_write_ready, data_vld, data_in,
        output data_out, data_oe, addr_wvalid, dram_addr, command_type, done, err
    );
endinterface

// File: rtl/chip_dram_if_model.sv
// Chip-side DRAM access model: burst-reads BEATS beats, optionally XORs them with KEY,
// and writes them back over the shared bus. Every output comes straight from a flop.
module chip_dram_if_model #(
    parameter int           BEATS   = 8,
    parameter logic [19:0]  RD_BASE = 20'h00000,
    parameter logic [19:0]  WR_BASE = 20'h01000,
    parameter logic [127:0] KEY     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    parameter int           TIMEOUT = 4096
) (
    input  logic                 clk_dly,
    input  logic                 rst,
    chip_dram_if_model_if.slave  bus
);
    localparam int CW = $clog2(BEATS + 1);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] B_LAST = CW'(BEATS - 1);
    localparam logic [CW-1:0] B_ALL  = CW'(BEATS);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_PRE, WR_DATA, WR_POST, DONE} state_t;

    state_t         state_q, state_d;
    logic           pend_q, pend_d;
    logic           enc_q, enc_d;
    logic [CW-1:0]  cnt_q, cnt_d, nxt_cnt;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           vld_q;
    logic           cap;
    logic           awv_q, awv_d, cmd_q, cmd_d, oe_q, oe_d, done_q, done_d, err_q, err_d;
    logic [19:0]    addr_q, addr_d;
    logic [127:0]   dout_q, dout_d;
    logic [127:0]   rbuf [BEATS];

    function automatic logic [127:0] mix_beat(input logic [127:0] beat, input logic enc);
        return enc ? (beat ^ KEY) : beat;
    endfunction

    assign nxt_cnt = cnt_q + 1'b1;
    // A beat is only real once data_vld has been high for a cycle: the first high cycle is the lead-in.
    assign cap = (state_q == RD_WAIT) && vld_q && bus.data_vld && (rcnt_q != B_ALL);

    // Next-state and next-output logic; the *_d values are what the outputs show next cycle.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        enc_d   = enc_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        tcnt_d  = tcnt_q;
        awv_d   = 1'b0;
        cmd_d   = 1'b0;
        oe_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.execute && !pend_q) begin
                    enc_d  = bus.encrypt;
                    err_d  = 1'b0;
                    rcnt_d = '0;
                    cnt_d  = '0;
                    tcnt_d = '0;
                end
                if ((bus.execute || pend_q) && bus.dram_read_ready) begin
                    state_d = RD_REQ;
                    pend_d  = 1'b0;
                    awv_d   = 1'b1;
                    addr_d  = RD_BASE;
                    cnt_d   = '0;
                end else if (bus.execute) begin
                    pend_d = 1'b1;
                end
            end
            RD_REQ: begin
                if (cnt_q == B_ALL) begin
                    state_d = RD_WAIT;
                    tcnt_d  = '0;
                end else begin
                    awv_d  = 1'b1;
                    addr_d = RD_BASE + 20'(cnt_q);
                    cnt_d  = nxt_cnt;
                end
            end
            RD_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                if (cap) rcnt_d = rcnt_q + 1'b1;
                if (cap && rcnt_q == B_LAST) begin
                    state_d = WR_PRE;
                    cmd_d   = 1'b1;
                    awv_d   = bus.dram_write_ready;
                end else if (tcnt_q == T_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            WR_PRE: begin
                cmd_d = 1'b1;
                if (awv_q) begin
                    state_d = WR_DATA;
                    awv_d   = 1'b1;
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    addr_d  = WR_BASE;
                    dout_d  = mix_beat(rbuf[0], enc_q);
                end else begin
                    awv_d = bus.dram_write_ready;
                end
            end
            WR_DATA: begin
                cmd_d = 1'b1;
                if (cnt_q == B_LAST) begin
                    state_d = WR_POST;
                end else begin
                    awv_d  = 1'b1;
                    oe_d   = 1'b1;
                    cnt_d  = nxt_cnt;
                    addr_d = WR_BASE + 20'(nxt_cnt);
                    dout_d = mix_beat(rbuf[nxt_cnt[IW-1:0]], enc_q);
                end
            end
            WR_POST: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_dly) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            enc_q   <= 1'b0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            vld_q   <= 1'b0;
            awv_q   <= 1'b0;
            cmd_q   <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            enc_q   <= enc_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            vld_q   <= bus.data_vld;
            awv_q   <= awv_d;
            cmd_q   <= cmd_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // Read-beat buffer: data only, never reset.
    always_ff @(posedge clk_dly) begin
        if (cap) rbuf[rcnt_q[IW-1:0]] <= bus.data_in;
    end

    assign bus.data_out     = dout_q;
    assign bus.data_oe      = oe_q;
    assign bus.addr_wvalid  = awv_q;
    assign bus.dram_addr    = addr_q;
    assign bus.command_type = cmd_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_chip_dram_if_model.sv
// Bench for chip_dram_if_model: acts as the FPGA harness and compares every bus transaction
// with a transaction-level expectation built from base addresses, beat data and the key.
module tb_chip_dram_if_model;
    localparam logic [127:0] KEY  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [19:0]  A_RD = 20'h00000;
    localparam logic [19:0]  B_RD = 20'hFFFFE;
    localparam logic [19:0]  WR   = 20'h01000;

    logic         clk_dly = 1'b0;
    logic         rst = 1'b1;
    logic         exec_a = 1'b0, exec_b = 1'b0;
    logic         encrypt = 1'b0, rd_rdy = 1'b1, wr_rdy = 1'b1, data_vld = 1'b0;
    logic [127:0] data_in = '0;
    logic         sel = 1'b0;
    int           n_pass = 0, n_total = 0;

    chip_dram_if_model_if ifa ();
    chip_dram_if_model_if ifb ();

    assign ifa.execute = exec_a;             assign ifb.execute = exec_b;
    assign ifa.encrypt = encrypt;            assign ifb.encrypt = encrypt;
    assign ifa.dram_read_ready = rd_rdy;     assign ifb.dram_read_ready = rd_rdy;
    assign ifa.dram_write_ready = wr_rdy;    assign ifb.dram_write_ready = wr_rdy;
    assign ifa.data_vld = data_vld;          assign ifb.data_vld = data_vld;
    assign ifa.data_in = data_in;            assign ifb.data_in = data_in;

    chip_dram_if_model #(.BEATS(8), .TIMEOUT(64)) dut_a (.clk_dly(clk_dly), .rst(rst), .bus(ifa.slave));
    chip_dram_if_model #(.BEATS(4), .RD_BASE(20'hFFFFE)) dut_b (.clk_dly(clk_dly), .rst(rst), .bus(ifb.slave));

    always #5 clk_dly = ~clk_dly;

    logic         o_awv, o_cmd, o_oe, o_done, o_err;
    logic [19:0]  o_addr;
    logic [127:0] o_dout;
    assign o_awv  = sel ? ifb.addr_wvalid  : ifa.addr_wvalid;
    assign o_cmd  = sel ? ifb.command_type : ifa.command_type;
    assign o_oe   = sel ? ifb.data_oe      : ifa.data_oe;
    assign o_done = sel ? ifb.done         : ifa.done;
    assign o_err  = sel ? ifb.err          : ifa.err;
    assign o_addr = sel ? ifb.dram_addr    : ifa.dram_addr;
    assign o_dout = sel ? ifb.data_out     : ifa.data_out;

    // Harness-side view of the bus, gathered once per cycle.
    int           cyc = 0, done_cnt = 0, done_cyc = 0, last_oe = 0, bad_bus = 0;
    logic         prev_awv = 1'b0;
    logic [19:0]  rd_q [$];
    logic [19:0]  wa_q [$];
    logic [127:0] wd_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_dly);
        #1;
        cyc++;
        if (o_awv && !o_cmd) rd_q.push_back(o_addr);
        if (o_awv && prev_awv && o_cmd) begin
            wa_q.push_back(o_addr);
            wd_q.push_back(o_dout);
            if (!o_oe) bad_bus++;
        end
        if (o_oe && !(o_awv && o_cmd)) bad_bus++;
        if (o_oe) last_oe = cyc;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_awv = o_awv;
    endtask

    // mode: 0 = beats 1..N, 1 = all zero, 2 = random. gap_at>0 splits the read data there.
    task automatic run_txn(input string name, input bit use_b, input bit enc, input int mode,
                           input int gap_at, input int stall, input bit no_data, input int rst_beat);
        int           nb = use_b ? 4 : 8;
        logic [19:0]  rb = use_b ? B_RD : A_RD;
        logic [127:0] d [8];
        int           n;
        sel = use_b;
        for (int k = 0; k < 8; k++)
            d[k] = (mode == 0) ? 128'(k + 1) : (mode == 1) ? 128'(0) : {$urandom, $urandom, $urandom, $urandom};
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0; bad_bus = 0;
        encrypt = enc; rd_rdy = 1'b1; wr_rdy = (stall == 0);
        if (use_b) exec_b = 1'b1; else exec_a = 1'b1;
        tick();
        exec_a = 1'b0; exec_b = 1'b0; encrypt = 1'($urandom);
        check({name, " start awv/cmd/err"}, 128'({o_awv, o_cmd, o_err}), 128'(3'b100));

        n = 0;
        while (o_awv && n < 300) begin tick(); n++; end
        check({name, " read req cycles"}, 128'(n), 128'(nb + 1));

        if (no_data) begin
            n = 0;
            while (!o_done && n < 200) begin tick(); n++; end
            check({name, " timeout cycles"}, 128'(n), 128'(64));
            check({name, " timeout err"}, 128'(o_err), 128'(1));
            tick();
            check({name, " timeout done width"}, 128'(o_done), 128'(0));
            check({name, " timeout write beats"}, 128'(wa_q.size()), 128'(0));
            return;
        end

        data_in = {$urandom, $urandom, $urandom, $urandom};
        data_vld = 1'b1;
        tick();
        for (int k = 0; k < nb; k++) begin
            if (k == gap_at && gap_at > 0) begin
                data_vld = 1'b0;
                repeat (4) tick();
                data_in = {$urandom, $urandom, $urandom, $urandom};
                data_vld = 1'b1;
                tick();
            end
            data_in = d[k];
            tick();
        end
        data_vld = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};

        if (stall > 0) begin
            int bad = 0;
            for (int s = 0; s < stall; s++) begin
                if (o_awv || o_oe || !o_cmd) bad++;
                tick();
            end
            check({name, " stall quiet cycles"}, 128'(bad), 128'(0));
            wr_rdy = 1'b1;
            tick();
        end
        check({name, " write preamble awv/cmd/oe"}, 128'({o_awv, o_cmd, o_oe}), 128'(3'b110));

        if (rst_beat >= 0) begin
            tick();
            repeat (rst_beat) tick();
            check({name, " beat before reset oe/addr"}, 128'({o_oe, o_addr}), 128'({1'b1, 20'(WR + 20'(rst_beat))}));
            rst = 1'b1;
            tick();
            check({name, " after reset oe/cmd/awv"}, 128'({o_oe, o_cmd, o_awv}), 128'(0));
            rst = 1'b0;
            tick();
            check({name, " no done after reset"}, 128'(done_cnt), 128'(0));
            return;
        end

        n = 0;
        while (!o_done && n < nb + 20) begin tick(); n++; end
        check({name, " done seen"}, 128'(o_done), 128'(1));
        check({name, " done after last write"}, 128'(done_cyc - last_oe), 128'(2));
        tick();
        check({name, " done pulses"}, 128'({o_done, 8'(done_cnt)}), 128'({1'b0, 8'd1}));
        check({name, " err"}, 128'(o_err), 128'(0));
        check({name, " bus rule"}, 128'(bad_bus), 128'(0));

        check({name, " read count"}, 128'(rd_q.size()), 128'(nb + 1));
        for (int k = 0; k <= nb; k++)
            if (k < rd_q.size())
                check({name, $sformatf(" read addr %0d", k)}, 128'(rd_q[k]),
                      128'(20'((rb + (k == 0 ? 0 : k - 1)) % 32'h100000)));
        check({name, " write count"}, 128'(wa_q.size()), 128'(nb));
        for (int k = 0; k < nb; k++)
            if (k < wa_q.size()) begin
                check({name, $sformatf(" write addr %0d", k)}, 128'(wa_q[k]), 128'(20'((WR + k) % 32'h100000)));
                check({name, $sformatf(" write data %0d", k)}, wd_q[k], enc ? (d[k] ^ KEY) : d[k]);
            end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("reset A strobes", 128'({ifa.addr_wvalid, ifa.command_type, ifa.data_oe, ifa.done, ifa.err}), 128'(0));
        check("reset A data/addr", 128'({ifa.data_out, ifa.dram_addr}), 128'(0));
        check("reset B strobes", 128'({ifb.addr_wvalid, ifb.command_type, ifb.data_oe, ifb.done, ifb.err}), 128'(0));
        check("reset B data/addr", 128'({ifb.data_out, ifb.dram_addr}), 128'(0));
        rst = 1'b0;
        tick();

        run_txn("pass",  1'b0, 1'b0, 0, 0, 0,  1'b0, -1);
        run_txn("enc",   1'b0, 1'b1, 1, 0, 0,  1'b0, -1);
        run_txn("gap",   1'b0, 1'b0, 2, 3, 0,  1'b0, -1);
        run_txn("stall", 1'b0, 1'b1, 2, 0, 20, 1'b0, -1);
        run_txn("tmo",   1'b0, 1'b0, 2, 0, 0,  1'b1, -1);
        run_txn("clr",   1'b0, 1'($urandom), 2, 0, 0, 1'b0, -1);
        run_txn("rst",   1'b0, 1'b1, 2, 0, 0,  1'b0, 3);
        run_txn("post",  1'b0, 1'b0, 2, 5, 0,  1'b0, -1);
        run_txn("wrap",  1'b1, 1'b1, 2, 0, 0,  1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
